// File: rtl/d_mem_ctrl.sv
// Data-memory access sequencer: decodes EX/MEM load/store requests, runs a ready-handshake access,
// stalls the pipeline meanwhile and returns aligned/extended load data. Define D_MEM_TIMEOUT_EN to abort hung accesses.
module d_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_mem_r,
    input  logic        d_mem_w,
    input  logic [2:0]  fun_3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_readdata,
    input  logic        mem_ready,
    output logic [31:0] load_data,
    output logic        busy_wait,
    output logic        access_fault
);

    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("d_mem_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_reg, state_next;
    logic        mem_read_reg, mem_read_next;
    logic        mem_write_reg, mem_write_next;
    logic [31:0] mem_address_reg, mem_address_next;
    logic [31:0] mem_writedata_reg, mem_writedata_next;
    logic [3:0]  mem_byteen_reg, mem_byteen_next;
    logic [31:0] load_data_reg, load_data_next;
    logic        fault_reg, fault_next;
    logic [2:0]  fun3_reg, fun3_next;
    logic [1:0]  lo_reg, lo_next;
    logic        timeout;

    // Request decode
    logic       req_any, legal_f3, aligned, req_valid;
    logic [3:0] st_byteen;
    logic [31:0] st_data;

    always_comb begin
        req_any  = d_mem_r | d_mem_w;
        legal_f3 = 1'b0;
        aligned  = 1'b1;
        case (fun_3)
            3'b000: legal_f3 = 1'b1;
            3'b001: begin legal_f3 = 1'b1; aligned = ~address[0]; end
            3'b010: begin legal_f3 = 1'b1; aligned = (address[1:0] == 2'b00); end
            3'b100: legal_f3 = d_mem_r;
            3'b101: begin legal_f3 = d_mem_r; aligned = ~address[0]; end
            default: legal_f3 = 1'b0;
        endcase
        req_valid = (d_mem_r ^ d_mem_w) & legal_f3 & aligned;

        case (fun_3[1:0])
            2'b00: begin
                st_byteen = 4'b0001 << address[1:0];
                st_data   = {4{write_data[7:0]}};
            end
            2'b01: begin
                st_byteen = address[1] ? 4'b1100 : 4'b0011;
                st_data   = {2{write_data[15:0]}};
            end
            default: begin
                st_byteen = 4'b1111;
                st_data   = write_data;
            end
        endcase
    end

    // Load extraction from the latched size/sign and byte offset
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (lo_reg)
            2'd0:    ld_byte = mem_readdata[7:0];
            2'd1:    ld_byte = mem_readdata[15:8];
            2'd2:    ld_byte = mem_readdata[23:16];
            default: ld_byte = mem_readdata[31:24];
        endcase
        ld_half = lo_reg[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        case (fun3_reg)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_readdata;
        endcase
    end

`ifdef D_MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE)
            cnt_next = '0;
        else if (state_reg == ACCESS)
            cnt_next = cnt_reg + 1'b1;
    end

    // Fires in the last permitted ACCESS cycle, so the strobe is up for exactly TIMEOUT_CYCLES cycles
    assign timeout = (state_reg == ACCESS) && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next         = state_reg;
        mem_read_next      = mem_read_reg;
        mem_write_next     = mem_write_reg;
        mem_address_next   = mem_address_reg;
        mem_writedata_next = mem_writedata_reg;
        mem_byteen_next    = mem_byteen_reg;
        load_data_next     = load_data_reg;
        fault_next         = 1'b0;
        fun3_next          = fun3_reg;
        lo_next            = lo_reg;
        busy_wait          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    busy_wait        = 1'b1;
                    state_next       = ACCESS;
                    mem_read_next    = d_mem_r;
                    mem_write_next   = d_mem_w;
                    mem_address_next = {address[31:2], 2'b00};
                    mem_byteen_next  = d_mem_r ? 4'b1111 : st_byteen;
                    if (d_mem_w)
                        mem_writedata_next = st_data;
                    fun3_next = fun_3;
                    lo_next   = address[1:0];
                end else if (req_any) begin
                    fault_next = 1'b1;
                end
            end
            ACCESS: begin
                busy_wait = 1'b1;
                if (mem_ready) begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    if (mem_read_reg)
                        load_data_next = ld_ext;
                    state_next = DONE;
                end else if (timeout) begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    fault_next     = 1'b1;
                    state_next     = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_address_reg   <= '0;
            mem_writedata_reg <= '0;
            mem_byteen_reg    <= '0;
            load_data_reg     <= '0;
            fault_reg         <= 1'b0;
            fun3_reg          <= '0;
            lo_reg            <= '0;
        end else begin
            state_reg         <= state_next;
            mem_read_reg      <= mem_read_next;
            mem_write_reg     <= mem_write_next;
            mem_address_reg   <= mem_address_next;
            mem_writedata_reg <= mem_writedata_next;
            mem_byteen_reg    <= mem_byteen_next;
            load_data_reg     <= load_data_next;
            fault_reg         <= fault_next;
            fun3_reg          <= fun3_next;
            lo_reg            <= lo_next;
        end
    end

    assign mem_read      = mem_read_reg;
    assign mem_write     = mem_write_reg;
    assign mem_address   = mem_address_reg;
    assign mem_writedata = mem_writedata_reg;
    assign mem_byteen    = mem_byteen_reg;
    assign load_data     = load_data_reg;
    assign access_fault  = fault_reg;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Testbench for d_mem_ctrl: directed vector table, reset/idle corner sequences and
// randomized transactions checked against a byte-arithmetic reference model.
module tb_d_mem_ctrl;

`ifdef D_MEM_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        d_mem_r = 1'b0, d_mem_w = 1'b0;
    logic [2:0]  fun_3 = '0;
    logic [31:0] address = '0, write_data = '0;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_writedata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_readdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] load_data;
    logic        busy_wait, access_fault;

    d_mem_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .d_mem_r(d_mem_r), .d_mem_w(d_mem_w), .fun_3(fun_3),
        .address(address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_byteen(mem_byteen), .mem_readdata(mem_readdata),
        .mem_ready(mem_ready), .load_data(load_data),
        .busy_wait(busy_wait), .access_fault(access_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, w;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        int          wait_n;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_load;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_load = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int wait_n,
                                input logic fault, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] ld);
        vec_t v;
        v.r = r; v.w = w; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.wait_n = wait_n; v.exp_fault = fault; v.exp_be = be;
        v.exp_wdata = wdata; v.exp_load = ld;
        return v;
    endfunction

    // Reference model: access size from funct3, expectations by shifting and masking
    function automatic vec_t model(input logic r, input logic w, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rdata, input int wait_n);
        vec_t v;
        int bytes, ofs;
        logic legal;
        longint mask, val;
        bytes = 1 << f3[1:0];
        ofs   = int'(addr % 4);
        legal = r ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        v = mk(r, w, f3, addr, wd, rdata, wait_n, 1'b0, 4'h0, 32'h0, 32'h0);
        v.exp_fault = !((r != w) && legal && ((addr % bytes) == 0));
        v.exp_be    = r ? 4'hF : 4'(((1 << bytes) - 1) << ofs);
        if (bytes == 1)      v.exp_wdata = {24'd0, wd[7:0]} * 32'h01010101;
        else if (bytes == 2) v.exp_wdata = {16'd0, wd[15:0]} * 32'h00010001;
        else                 v.exp_wdata = wd;
        if (bytes >= 4) begin
            v.exp_load = rdata;
        end else begin
            mask = (64'd1 << (8 * bytes)) - 1;
            val  = longint'(rdata >> (8 * ofs)) & mask;
            if (!f3[2] && ((val >> (8 * bytes - 1)) & 1) == 1)
                val = val - (mask + 1);
            v.exp_load = 32'(val);
        end
        return v;
    endfunction

    task automatic run_txn(input string tag, input vec_t v);
        int busy_cnt;
        logic valid;
        busy_cnt = 0;
        valid = !v.exp_fault;
        @(posedge clk); #1;
        d_mem_r = v.r; d_mem_w = v.w; fun_3 = v.f3;
        address = v.addr; write_data = v.wd;
        mem_ready = 1'b0; mem_readdata = $urandom;
        @(negedge clk);
        check({tag, " busy_req"}, {31'd0, busy_wait}, {31'd0, valid});
        if (busy_wait) busy_cnt++;
        if (!valid) begin
            @(posedge clk); #1;
            d_mem_r = 1'b0; d_mem_w = 1'b0;
            @(negedge clk);
            check({tag, " fault_on"}, {31'd0, access_fault}, 32'd1);
            check({tag, " no_strobe"}, {30'd0, mem_read, mem_write}, 32'd0);
            check({tag, " busy_fault"}, {31'd0, busy_wait}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, " fault_off"}, {31'd0, access_fault}, 32'd0);
            $display("TXN %s r=%0b w=%0b f3=%0d addr=0x%08h -> fault", tag, v.r, v.w, v.f3, v.addr);
        end else begin
            for (int k = 1; k <= v.wait_n; k++) begin
                @(posedge clk); #1;
                mem_ready = (k == v.wait_n);
                mem_readdata = mem_ready ? v.rdata : $urandom;
                @(negedge clk);
                check({tag, " strobes"}, {30'd0, mem_read, mem_write}, {30'd0, v.r, v.w});
                check({tag, " mem_address"}, mem_address, v.addr & 32'hFFFF_FFFC);
                check({tag, " byteen"}, {28'd0, mem_byteen}, {28'd0, v.exp_be});
                if (v.w) check({tag, " writedata"}, mem_writedata, v.exp_wdata);
                check({tag, " fault_acc"}, {31'd0, access_fault}, 32'd0);
                if (busy_wait) busy_cnt++;
            end
            @(posedge clk); #1;
            mem_ready = 1'b0; mem_readdata = $urandom;
            @(negedge clk);
            if (v.r) last_load = v.exp_load;
            check({tag, " busy_done"}, {31'd0, busy_wait}, 32'd0);
            check({tag, " strobes_done"}, {30'd0, mem_read, mem_write}, 32'd0);
            check({tag, " load_data"}, load_data, last_load);
            check({tag, " fault_done"}, {31'd0, access_fault}, 32'd0);
            check({tag, " stall_cycles"}, busy_cnt, v.wait_n + 1);
            @(posedge clk); #1;
            d_mem_r = 1'b0; d_mem_w = 1'b0;
            $display("TXN %s r=%0b w=%0b f3=%0d addr=0x%08h wait=%0d load=0x%08h stall=%0d",
                     tag, v.r, v.w, v.f3, v.addr, v.wait_n, load_data, busy_cnt);
        end
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 4'hF, 32'h0, 32'hDEADBEEF);
        tbl[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 0, 4'hF, 32'h0, 32'hFFFFFF80);
        tbl[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 0, 4'hF, 32'h0, 32'h00000080);
        tbl[3]  = mk(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 2, 0, 4'hC, 32'hABCDABCD, 32'h0);
        tbl[4]  = mk(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
        tbl[5]  = mk(0, 1, 3'b001, 32'h203, 32'h1234, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
        tbl[6]  = mk(1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 2, 0, 4'hF, 32'h0, 32'hFFFF8011);
        tbl[7]  = mk(1, 0, 3'b101, 32'h000, 32'h0, 32'h80112233, 1, 0, 4'hF, 32'h0, 32'h00002233);
        tbl[8]  = mk(0, 1, 3'b000, 32'h301, 32'h123456A5, 32'h0, 1, 0, 4'h2, 32'hA5A5A5A5, 32'h0);
        tbl[9]  = mk(0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 4, 0, 4'hF, 32'hCAFEF00D, 32'h0);
        tbl[10] = mk(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
        tbl[11] = mk(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
        tbl[12] = mk(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
        tbl[13] = mk(1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 0, 4'hF, 32'h0, 32'h0000007F);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst mem_address", mem_address, 32'd0);
        check("rst writedata", mem_writedata, 32'd0);
        check("rst byteen", {28'd0, mem_byteen}, 32'd0);
        check("rst load_data", load_data, 32'd0);
        check("rst fault", {31'd0, access_fault}, 32'd0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 14; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // mem_ready while idle must not disturb anything
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_readdata = 32'h5555AAAA;
        @(negedge clk);
        check("idle_rdy strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("idle_rdy busy", {31'd0, busy_wait}, 32'd0);
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        check("idle_rdy load_data", load_data, last_load);
        check("idle_rdy fault", {31'd0, access_fault}, 32'd0);
        $display("TXN idle_ready load=0x%08h", load_data);

        // Reset asserted mid-ACCESS, late mem_ready afterwards
        @(posedge clk); #1;
        d_mem_r = 1'b1; fun_3 = 3'b010; address = 32'h100;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstacc strobe_before", {31'd0, mem_read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstacc strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rstacc load_data", load_data, 32'd0);
        check("rstacc fault", {31'd0, access_fault}, 32'd0);
        d_mem_r = 1'b0;
        #1;
        check("rstacc busy_idle", {31'd0, busy_wait}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_readdata = 32'h12345678;
        @(negedge clk);
        check("rstacc late_rdy strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rstacc late_rdy busy", {31'd0, busy_wait}, 32'd0);
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        check("rstacc late_rdy load", load_data, 32'd0);
        check("rstacc late_rdy fault", {31'd0, access_fault}, 32'd0);
        last_load = 32'd0;
        $display("TXN reset_mid_access load=0x%08h", load_data);

`ifdef D_MEM_TIMEOUT_EN
        // Hung access: strobe for TO_CYC ACCESS cycles, then fault pulse in DONE
        @(posedge clk); #1;
        d_mem_r = 1'b1; fun_3 = 3'b010; address = 32'h100;
        for (int k = 1; k <= TO_CYC; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("tmo strobe", {31'd0, mem_read}, 32'd1);
            check("tmo busy", {31'd0, busy_wait}, 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("tmo strobe_drop", {31'd0, mem_read}, 32'd0);
        check("tmo fault", {31'd0, access_fault}, 32'd1);
        check("tmo busy_done", {31'd0, busy_wait}, 32'd0);
        check("tmo load_kept", load_data, last_load);
        @(posedge clk); #1; d_mem_r = 1'b0;
        @(negedge clk);
        check("tmo fault_off", {31'd0, access_fault}, 32'd0);
        $display("TXN timeout after %0d cycles", TO_CYC);
`endif

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic r, w;
            logic [2:0] f3;
            logic [31:0] a;
            kind = $urandom_range(0, 5);
            r = (kind <= 2) || (kind == 5);
            w = (kind >= 3);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (r && !w) f3 = (kind == 0) ? 3'b100 + 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 2));
            else f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & ~(32'((1 << f3[1:0]) - 1));
            run_txn($sformatf("rnd%0d", i),
                    model(r, w, f3, a, $urandom, $urandom, int'($urandom_range(1, 4))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/d_mem_ctrl.md
Name: d_mem_ctrl

Overview:
- Data-memory access sequencer between the EX/MEM pipeline register and the data memory / D-cache port.
- Decodes the latched load/store request (d_mem_r, d_mem_w, fun_3, address, store data).
- Drives a multi-cycle ready-handshake memory, holds the pipeline with busy_wait until the access completes, then returns aligned and extended load data.
- Detects misaligned and illegal accesses without touching memory.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in ACCESS before abort (used only with the optional feature).
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_mem_r  in  1  load request from the EX/MEM register.
- d_mem_w  in  1  store request from the EX/MEM register.
- fun_3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- address  in  32  effective byte address (ALU result).
- write_data  in  32  store source (rs2 value).
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  32  word address, {address[31:2], 2'b00}.
- mem_writedata  out  32  lane-replicated store data.
- mem_byteen  out  4  byte-lane enables.
- mem_readdata  in  32  raw word returned by memory.
- mem_ready  in  1  memory completion, valid for one cycle.
- load_data  out  32  extracted and extended load result.
- busy_wait  out  1  pipeline stall, combinational.
- access_fault  out  1  one-cycle pulse on a misaligned, illegal or (optionally) timed-out access.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteen=0.
  - load_data=0, access_fault=0, timeout counter=0.
  - Reset during ACCESS drops the strobes immediately; any late mem_ready is ignored.
- Request validity: exactly one of d_mem_r / d_mem_w is high, fun_3 is legal for the direction (loads: 000, 001, 010, 100, 101; stores: 000, 001, 010), and the address is aligned (H: addr[0]=0; W: addr[1:0]=0).
- IDLE:
  - Valid request: latch the request, go to ACCESS. The matching strobe registers high; busy_wait=1 in this same cycle.
  - Invalid request (misaligned, illegal fun_3, or r and w both high): no memory strobe, access_fault=1 for the next cycle, busy_wait=0, remain in IDLE.
  - No request: outputs unchanged, except access_fault clears.
- ACCESS:
  - busy_wait=1; strobe and address stay stable.
  - On mem_ready=1: strobes go to 0. For a load, register load_data. Go to DONE.
- DONE:
  - busy_wait=0, so the pipeline advances at this edge.
  - Request inputs are ignored (they are still the completed instruction). Return to IDLE.
- Minimum latency: request in cycle 0, mem_ready in cycle 1, DONE in cycle 2. That gives 2 stall cycles; each additional wait cycle adds one.
- Store formatting:
  - B: byteen=4'b0001<<addr[1:0], data={4{wd[7:0]}}.
  - H: byteen=addr[1]?4'b1100:4'b0011, data={2{wd[15:0]}}.
  - W: byteen=4'b1111, data=wd.
  - Loads drive byteen=4'b1111.
- Load extraction:
  - Byte select uses addr[1:0]; half select uses addr[1].
  - 000/001 sign-extend; 100/101 zero-extend; 010 passes the word through.
- mem_ready while in IDLE or DONE is ignored.

Optional Feature:
- Macro: D_MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready: drop strobes, leave load_data unchanged, pulse access_fault in the DONE cycle, then go to DONE.
- Undefined: no counter; ACCESS waits indefinitely for mem_ready.

Test Plan:
- LW, addr 0x100, mem_readdata 0xDEADBEEF, mem_ready 3 cycles after the strobe. Required: mem_address=0x100, byteen=1111, busy_wait high for 4 cycles, load_data=0xDEADBEEF in DONE.
- LB at 0x103, then LBU at 0x103, readdata 0x80112233. Required: load_data=0xFFFFFF80, then 0x00000080.
- SH at 0x202, wd=0x0000ABCD. Required: mem_address=0x200, byteen=1100, mem_writedata=0xABCDABCD, mem_write high until mem_ready.
- LW at 0x101, and SH at 0x203. Required: no strobe, busy_wait=0, access_fault pulses exactly 1 cycle in each case.
- reset=0 asserted mid-ACCESS, mem_ready arriving 1 cycle later. Required: strobes low immediately, state IDLE, load_data=0, no fault.
- With D_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready never asserted. Required: strobe drops after 8 ACCESS cycles, access_fault pulses once, busy_wait falls in DONE.
